csa_resolver: RTL and testbench

Resolves a redundant carry-save pair (sum vector, carry vector), as produced by a 4:2 compressor tree, into a single binary result. It uses one CHUNK-bit adder slice, processing one chunk per clock. The block sits at the output of a multiplier or multi-operand reduction array, in place of a full-width carry-propagate adder, trading latency for area. Both sides use valid/ready handshakes.

---
 rtl/csa_pkg.sv | 18 +
 rtl/csa_chunk_adder.sv | 14 +
 rtl/csa_resolver.sv | 109 ++++++++++
 tb/tb_csa_resolver.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/csa_pkg.sv
// Shared types and helpers for the chunked carry-save resolver.
package csa_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_DONE = 2'd2
   } state_e;

   function automatic int num_chunks(input int width, input int chunk);
      return width / chunk;
   endfunction

   function automatic bit chunk_ok(input int width, input int chunk);
      return (chunk > 0) && (width >= chunk) && ((width % chunk) == 0);
   endfunction

endpackage

// File: rtl/csa_chunk_adder.sv
// Combinational CHUNK-bit adder slice with carry-in and carry-out.
module csa_chunk_adder #(
   parameter int CHUNK = 8
) (
   input  logic [CHUNK-1:0] a_i,
   input  logic [CHUNK-1:0] b_i,
   input  logic             c_i,
   output logic [CHUNK-1:0] s_o,
   output logic             c_o
);

   assign {c_o, s_o} = {1'b0, a_i} + {1'b0, b_i} + {{CHUNK{1'b0}}, c_i};

endmodule

// File: rtl/csa_resolver.sv
// Resolves a sum/carry pair into binary, one CHUNK-bit slice per cycle.
module csa_resolver
   import csa_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int CHUNK = 8
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_valid,
   output logic             o_ready,
   input  logic [WIDTH-1:0] i_sum,
   input  logic [WIDTH-1:0] i_carry,
   output logic             o_valid,
   input  logic             i_ready,
   output logic [WIDTH:0]   o_result
);

   localparam int N  = num_chunks(WIDTH, CHUNK);
   localparam int KW = (N > 1) ? $clog2(N) : 1;
   localparam logic [KW-1:0] K_LAST = KW'(N - 1);

   if (!chunk_ok(WIDTH, CHUNK)) begin : g_bad_chunk
      $error("csa_resolver: WIDTH must be a multiple of CHUNK");
   end

   state_e           state_q;
   logic [KW-1:0]    k_q;
   logic             c_q;
   logic [WIDTH-1:0] sum_q;
   logic [WIDTH-1:0] car_q;
   logic [WIDTH:0]   res_q;
   logic             ready_q;
   logic             valid_q;

   int               base;
   logic [CHUNK-1:0] a_k;
   logic [CHUNK-1:0] b_k;
   logic [CHUNK-1:0] s_d;
   logic             c_d;

   assign base = int'(k_q) * CHUNK;
   assign a_k  = sum_q[base +: CHUNK];
   assign b_k  = car_q[base +: CHUNK];

   csa_chunk_adder #(
      .CHUNK(CHUNK)
   ) u_add (
      .a_i(a_k),
      .b_i(b_k),
      .c_i(c_q),
      .s_o(s_d),
      .c_o(c_d)
   );

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         state_q <= ST_IDLE;
         k_q     <= '0;
         c_q     <= 1'b0;
         sum_q   <= '0;
         car_q   <= '0;
         res_q   <= '0;
         ready_q <= 1'b1;
         valid_q <= 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (i_valid && ready_q) begin
                  sum_q   <= i_sum;
                  car_q   <= i_carry;
                  k_q     <= '0;
                  c_q     <= 1'b0;
                  state_q <= ST_BUSY;
                  ready_q <= 1'b0;
               end
            end
            ST_BUSY: begin
               res_q[base +: CHUNK] <= s_d;
               c_q <= c_d;
               k_q <= k_q + KW'(1);
               // Last slice also lands the final carry-out in the top bit.
               if (k_q == K_LAST) begin
                  res_q[WIDTH] <= c_d;
                  state_q      <= ST_DONE;
                  valid_q      <= 1'b1;
               end
            end
            ST_DONE: begin
               if (i_ready) begin
                  state_q <= ST_IDLE;
                  valid_q <= 1'b0;
                  ready_q <= 1'b1;
               end
            end
            default: begin
               state_q <= ST_IDLE;
               valid_q <= 1'b0;
               ready_q <= 1'b1;
            end
         endcase
      end
   end

   assign o_ready  = ready_q;
   assign o_valid  = valid_q;
   assign o_result = res_q;

endmodule

// File: tb/tb_csa_resolver.sv
// Directed and randomized checks of csa_resolver against a 33-bit sum model.
module tb_csa_resolver;

   localparam int WIDTH = 32;
   localparam int CHUNK = 8;
   localparam int N     = WIDTH / CHUNK;

   logic             clk = 1'b0;
   logic             rst_n;
   logic             in_valid;
   logic             out_ready;
   logic [WIDTH-1:0] sum_v;
   logic [WIDTH-1:0] car_v;
   logic             out_valid;
   logic             in_ready;
   logic [WIDTH:0]   result;

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   csa_resolver #(
      .WIDTH(WIDTH),
      .CHUNK(CHUNK)
   ) dut (
      .i_clk   (clk),
      .i_rst_n (rst_n),
      .i_valid (in_valid),
      .o_ready (out_ready),
      .i_sum   (sum_v),
      .i_carry (car_v),
      .o_valid (out_valid),
      .i_ready (in_ready),
      .o_result(result)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [63:0] obs,
                        input logic [63:0] exp);
      tests++;
      assert (obs === exp)
      else begin
         fails++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic [WIDTH:0] ref_sum(input logic [WIDTH-1:0] a,
                                              input logic [WIDTH-1:0] b);
      return {1'b0, a} + {1'b0, b};
   endfunction

   // Issue one pair, verify latency and value, then retire it.
   task automatic run_op(input string tag, input logic [WIDTH-1:0] a,
                         input logic [WIDTH-1:0] b,
                         input logic [WIDTH:0] exp);
      check({tag, "_ready"}, 64'(out_ready), 64'd1);
      in_valid = 1'b1;
      sum_v    = a;
      car_v    = b;
      tick();
      in_valid = 1'b0;
      sum_v    = $urandom;
      car_v    = $urandom;
      for (int i = 1; i < N; i++) begin
         tick();
         check({tag, "_busy_valid"}, 64'(out_valid), 64'd0);
      end
      tick();
      check({tag, "_done_valid"}, 64'(out_valid), 64'd1);
      check({tag, "_result"}, 64'(result), 64'(exp));
      in_ready = 1'b1;
      tick();
      in_ready = 1'b0;
      check({tag, "_back_idle"}, 64'(out_ready), 64'd1);
   endtask

   logic [WIDTH:0] q[$];
   logic [WIDTH:0] exp_v;
   logic [WIDTH:0] held;
   logic [WIDTH-1:0] a_r, b_r;
   logic acc, outh, stalled;
   int n_out, cyc, last_acc;

   initial begin
      rst_n    = 1'b0;
      in_valid = 1'b0;
      in_ready = 1'b0;
      sum_v    = '0;
      car_v    = '0;
      tick();
      tick();
      rst_n = 1'b1;
      check("rst_valid", 64'(out_valid), 64'd0);
      check("rst_ready", 64'(out_ready), 64'd1);
      check("rst_result", 64'(result), 64'd0);

      run_op("basic", 32'h0000_0001, 32'h0000_0001, 33'h0_0000_0002);
      run_op("ripple", 32'hFFFF_FFFF, 32'h0000_0001, 33'h1_0000_0000);
      run_op("max", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 33'h1_FFFF_FFFE);

      // Backpressure in DONE with new offers that must be ignored.
      in_valid = 1'b1;
      sum_v    = 32'hDEAD_BEEF;
      car_v    = 32'h1234_5678;
      held     = ref_sum(32'hDEAD_BEEF, 32'h1234_5678);
      tick();
      for (int i = 0; i < N; i++) begin
         in_valid = ~in_valid;
         sum_v    = $urandom;
         car_v    = $urandom;
         tick();
      end
      for (int i = 0; i < 5; i++) begin
         in_valid = ~in_valid;
         sum_v    = $urandom;
         car_v    = $urandom;
         check("bp_valid", 64'(out_valid), 64'd1);
         check("bp_result", 64'(result), 64'(held));
         check("bp_ready", 64'(out_ready), 64'd0);
         tick();
      end
      in_valid = 1'b0;
      in_ready = 1'b1;
      tick();
      in_ready = 1'b0;
      check("bp_release_ready", 64'(out_ready), 64'd1);
      check("bp_release_valid", 64'(out_valid), 64'd0);

      // Reset while k == 2.
      in_valid = 1'b1;
      sum_v    = 32'hAAAA_AAAA;
      car_v    = 32'h5555_5555;
      tick();
      in_valid = 1'b0;
      tick();
      tick();
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      check("midrst_valid", 64'(out_valid), 64'd0);
      check("midrst_ready", 64'(out_ready), 64'd1);
      check("midrst_result", 64'(result), 64'd0);
      for (int i = 0; i < N + 1; i++) begin
         tick();
         check("midrst_no_valid", 64'(out_valid), 64'd0);
      end
      run_op("post_rst", 32'h1234_5678, 32'h0FED_CBA8, 33'h0_2222_2220);

      // Streaming with random downstream stalls.
      in_valid = 1'b1;
      a_r      = $urandom;
      b_r      = $urandom;
      sum_v    = a_r;
      car_v    = b_r;
      n_out    = 0;
      cyc      = 0;
      last_acc = -1;
      stalled  = 1'b0;
      while (n_out < 1000 && cyc < 30000) begin
         in_ready = ($urandom_range(0, 3) != 0);
         acc  = in_valid && out_ready;
         outh = out_valid && in_ready;
         if (outh) begin
            if (q.size() == 0) begin
               check("rand_spurious", 64'(result), 64'h1_0000_0000_0000);
            end else begin
               exp_v = q.pop_front();
               check("rand_result", 64'(result), 64'(exp_v));
            end
            n_out++;
         end
         if (out_valid && !in_ready) stalled = 1'b1;
         if (acc) begin
            q.push_back(ref_sum(a_r, b_r));
            if (last_acc >= 0 && !stalled)
               check("issue_interval", 64'(cyc - last_acc), 64'(N + 2));
            last_acc = cyc;
            stalled  = 1'b0;
         end
         tick();
         cyc++;
         if (acc) begin
            case ($urandom_range(0, 7))
               0:       a_r = 32'hFFFF_FFFF;
               1:       a_r = '0;
               default: a_r = $urandom;
            endcase
            b_r   = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFF : $urandom;
            sum_v = a_r;
            car_v = b_r;
         end
      end
      in_valid = 1'b0;
      in_ready = 1'b0;
      check("rand_count", 64'(n_out), 64'd1000);
      check("rand_leftover", 64'(q.size()), 64'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
